// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-port memory between the multicycle CPU and a DMA.
// Round-robin tie-break by default; define MEM_ARB_CPU_PRIO_EN for fixed CPU priority.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wd,
  output logic [DW-1:0] dma_rd,
  output logic          dma_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  // LATENCY is limited to 1..15, so the 4-bit counter never wraps.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t        state;
  owner_t        owner;
  owner_t        last_owner;
  logic [3:0]    cnt;
  logic          lat_we;

  logic          grant_cpu;
  logic          grant_dma;
  logic          sel_we;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wd;

  always_comb begin
`ifdef MEM_ARB_CPU_PRIO_EN
    grant_cpu = cpu_req;
`else
    grant_cpu = cpu_req && (!dma_req || (last_owner == OWN_DMA));
`endif
    grant_dma = dma_req && !grant_cpu;
    sel_we    = grant_cpu ? cpu_we  : dma_we;
    sel_adr   = grant_cpu ? cpu_adr : dma_adr;
    sel_wd    = grant_cpu ? cpu_wd  : dma_wd;
  end

  // The write strobe is raised only for the final ACCESS cycle so a reset earlier in the
  // access can still cancel the write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= OWN_CPU;
      last_owner <= OWN_DMA;
      lat_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_adr    <= '0;
      mem_wd     <= '0;
      cpu_ready  <= 1'b0;
      dma_ready  <= 1'b0;
      cpu_rd     <= '0;
      dma_rd     <= '0;
    end else begin
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu || grant_dma) begin
            owner   <= grant_cpu ? OWN_CPU : OWN_DMA;
            lat_we  <= sel_we;
            mem_adr <= sel_adr;
            mem_wd  <= sel_wd;
            mem_we  <= sel_we && (CNT_INIT == 4'd0);
            mem_en  <= 1'b1;
            cnt     <= CNT_INIT;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (owner == OWN_CPU) begin
              cpu_rd    <= mem_rd;
              cpu_ready <= 1'b1;
            end else begin
              dma_rd    <= mem_rd;
              dma_ready <= 1'b1;
            end
            last_owner <= owner;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            state      <= DONE;
          end else begin
            cnt    <= cnt - 4'd1;
            mem_we <= lat_we && (cnt == 4'd1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a transaction-level model.
// Honours MEM_ARB_CPU_PRIO_EN for the expected tie-break rule.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // index 0 = CPU requester, index 1 = DMA requester
  logic          req [2];
  logic          we  [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wd  [2];
  logic [1:0][DW-1:0] rd;
  logic [1:0]         ready;

  logic          mem_en, mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd, mem_rd;

  mem_arbiter #(.AW(AW), .DW(DW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_adr(adr[0]), .cpu_wd(wd[0]),
    .cpu_rd(rd[0]), .cpu_ready(ready[0]),
    .dma_req(req[1]), .dma_we(we[1]), .dma_adr(adr[1]), .dma_wd(wd[1]),
    .dma_rd(rd[1]), .dma_ready(ready[1]),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Second instance with single-cycle memory, CPU side only.
  logic          l1_req;
  logic [DW-1:0] l1_rd, l1_dma_rd, l1_mem_wd;
  logic          l1_ready, l1_dma_ready, l1_mem_en, l1_mem_we;
  logic [AW-1:0] l1_mem_adr;

  mem_arbiter #(.AW(AW), .DW(DW), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .cpu_req(l1_req), .cpu_we(1'b0), .cpu_adr(32'h0000_0300), .cpu_wd(32'h0),
    .cpu_rd(l1_rd), .cpu_ready(l1_ready),
    .dma_req(1'b0), .dma_we(1'b0), .dma_adr(32'h0), .dma_wd(32'h0),
    .dma_rd(l1_dma_rd), .dma_ready(l1_dma_ready),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_adr(l1_mem_adr), .mem_wd(l1_mem_wd),
    .mem_rd(32'h0BAD_F00D)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 64) return 32'hDEAD_BEEF;
    return 32'hA500_0000 | DW'(i << 8) | DW'(i);
  endfunction

  // Behavioural memory seen by the DUT (256 words, word-addressed by adr[9:2]).
  logic [DW-1:0] phys_mem [256];
  bit mem_loaded = 1'b0;
  assign mem_rd = phys_mem[mem_adr[9:2]];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) phys_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      phys_mem[mem_adr[9:2]] <= mem_wd;
    end
  end

  typedef struct {
    int            owner;
    bit            we;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Transaction-level reference: one access at a time, occupying LAT+2 edges from grant to
  // the next possible grant; ties go to whoever was not served last.
  int            cyc = 0;
  logic [DW-1:0] ref_mem [256];
  bit            m_busy = 1'b0;
  bit            m_last_cpu = 1'b0;
  int            m_owner = 0;
  int            m_k = 0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_data = '0;
  bit            exp_en = 1'b0;
  bit            exp_we = 1'b0;
  logic [AW-1:0] exp_adr = '0;
  logic [DW-1:0] exp_wd = '0;

  always @(posedge clk) begin
    cyc++;
    if (cyc == 1) for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    if (reset) begin
      // A strobe already on the bus in the cycle just ending still lands in memory.
      if (m_busy && m_we && m_k == LAT - 1) ref_mem[m_adr[9:2]] = m_wd;
      m_busy     = 1'b0;
      m_last_cpu = 1'b0;
    end else begin
      if (m_busy) begin
        m_k++;
        if (m_k == LAT) begin
          m_data = ref_mem[m_adr[9:2]];
          if (m_we) ref_mem[m_adr[9:2]] = m_wd;
          m_last_cpu = (m_owner == 0);
          exp_q.push_back('{owner: m_owner, we: m_we, data: m_data});
        end
        if (m_k == LAT + 2) m_busy = 1'b0;
      end
      if (!m_busy && (req[0] || req[1])) begin
        if (req[0] && req[1]) begin
`ifdef MEM_ARB_CPU_PRIO_EN
          m_owner = 0;
`else
          m_owner = m_last_cpu ? 1 : 0;
`endif
        end else begin
          m_owner = req[0] ? 0 : 1;
        end
        m_we   = we[m_owner];
        m_adr  = adr[m_owner];
        m_wd   = wd[m_owner];
        m_k    = 0;
        m_busy = 1'b1;
      end
    end
    exp_en  = m_busy && (m_k < LAT);
    exp_we  = exp_en && m_we && (m_k == LAT - 1);
    exp_adr = m_adr;
    exp_wd  = m_wd;
  end

  // Monitor: bus activity every cycle, and each ready pulse against the scoreboard head.
  bit   mon_on = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_on) begin
      chk(mem_en === exp_en, "mem_en", 32'(mem_en), 32'(exp_en));
      chk(mem_we === exp_we, "mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_en) chk(mem_adr === exp_adr, "mem_adr", mem_adr, exp_adr);
      if (exp_we) chk(mem_wd === exp_wd, "mem_wd", mem_wd, exp_wd);
      for (int i = 0; i < 2; i++) begin
        if (ready[i]) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_ready", 32'(i), 32'hFFFF_FFFF);
          end else begin
            mon_e = exp_q.pop_front();
            chk(mon_e.owner == i, "ready_owner", 32'(i), 32'(mon_e.owner));
            if (!mon_e.we) chk(rd[i] === mon_e.data, "rd_data", rd[i], mon_e.data);
          end
        end
      end
      if (!ready[0] && !ready[1] && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk(1'b0, "missing_ready", 32'h0, 32'(mon_e.owner));
      end
    end
  end

  // Issue one access from requester id; call on a falling edge, returns on the ready cycle.
  task automatic do_access(input int id, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t;
    we[id]  = w;
    adr[id] = a;
    wd[id]  = d;
    req[id] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ready[id] && t < 200);
    if (!ready[id]) chk(1'b0, "ready_timeout", 32'(id), 32'h1);
    req[id] = 1'b0;
  endtask

  task automatic applyStimulus(input int id, input int n, input int max_gap);
    logic [AW-1:0] a;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      a = '0;
      a[9:2] = 8'($urandom_range(0, 255));
      do_access(id, 1'($urandom_range(0, 1)), a, DW'($urandom()));
    end
  endtask

  task automatic checkOutput();
    int bad;
    chk(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 32'h0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (phys_mem[i] !== ref_mem[i]) begin
        if (bad < 8) $display("[TB] FAIL mem_word[%0d]: got %h, expected %h", i, phys_mem[i], ref_mem[i]);
        bad++;
      end
    end
    chk(bad == 0, "mem_contents_bad_words", 32'(bad), 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int hits[$];
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wd[i] = '0;
    end
    l1_req = 1'b0;
    repeat (3) @(negedge clk);

    chk(ready[0] === 1'b0, "rst_cpu_ready", 32'(ready[0]), 32'h0);
    chk(ready[1] === 1'b0, "rst_dma_ready", 32'(ready[1]), 32'h0);
    chk(rd[0] === 32'h0, "rst_cpu_rd", rd[0], 32'h0);
    chk(rd[1] === 32'h0, "rst_dma_rd", rd[1], 32'h0);
    chk(mem_en === 1'b0, "rst_mem_en", 32'(mem_en), 32'h0);
    chk(mem_we === 1'b0, "rst_mem_we", 32'(mem_we), 32'h0);
    chk(mem_adr === 32'h0, "rst_mem_adr", mem_adr, 32'h0);
    chk(mem_wd === 32'h0, "rst_mem_wd", mem_wd, 32'h0);
    mon_on = 1'b1;
    reset  = 1'b0;
    @(negedge clk);

    // LATENCY=1: request seen at edge t0+1, ready after t0+2, then every 3 cycles.
    l1_req = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (l1_ready) begin
        hits.push_back(cyc);
        chk(l1_rd === 32'h0BAD_F00D, "l1_rd", l1_rd, 32'h0BAD_F00D);
      end
      chk(l1_dma_ready === 1'b0, "l1_dma_ready", 32'(l1_dma_ready), 32'h0);
      if (l1_mem_en) chk(l1_mem_adr === 32'h300, "l1_mem_adr", l1_mem_adr, 32'h300);
    end
    l1_req = 1'b0;
    chk(hits.size() == 4, "l1_ready_count", 32'(hits.size()), 32'h4);
    for (int k = 0; k < hits.size(); k++)
      chk(hits[k] == t0 + 2 + 3 * k, "l1_ready_cycle", 32'(hits[k] - t0), 32'(2 + 3 * k));
    repeat (3) @(negedge clk);

    // Both requesting back-to-back from reset state.
    fork
      applyStimulus(0, 2, 0);
      applyStimulus(1, 2, 0);
    join

    do_access(0, 1'b0, 32'h100, 32'h0);
    do_access(1, 1'b1, 32'h40, 32'h1234_5678);

    // DMA arrives while the CPU access is in flight.
    fork
      do_access(0, 1'b0, 32'h80, 32'h0);
      begin
        @(negedge clk);
        do_access(1, 1'b0, 32'hC4, 32'h0);
      end
    join

    // Reset during the first ACCESS cycle of a CPU write: the write must be dropped.
    @(negedge clk);
    we[0] = 1'b1; adr[0] = 32'h200; wd[0] = 32'h55AA_55AA; req[0] = 1'b1;
    @(negedge clk);
    reset = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_access(0, 1'b0, 32'h200, 32'h0);

    fork
      applyStimulus(0, 30, 2);
      applyStimulus(1, 30, 2);
    join

    repeat (6) @(negedge clk);
    checkOutput();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
